ex_mem_stage: RTL

- EX/MEM pipeline stage register. It consumes the EX-stage results and the control bundle carried forward from ID/EX, and presents registered operands and controls to the MEM stage.
- It also owns the architectural HI/LO pair, the syscall halt/display logic and the pipeline performance counters.
- A new instruction is accepted only on a load cycle. Flush inserts a bubble. A halt freezes the whole stage.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/perf_counter.sv | 27 ++
 rtl/ex_mem_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline stages: syscall service codes, the
// register-number width and the control bundle carried from ID/EX into EX/MEM.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int SYSCALL_EXIT  = 10;
    localparam int SYSCALL_PRINT = 34;
    localparam int REGNUM_W      = 6;

    // Control bits that travel with an instruction from EX into MEM.
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_to_reg;
        logic       to_lh;
        logic       syscall;
        logic       sh;
        logic       sb;
        logic       extr_signed;
        logic       jmp;
        logic       jal;
        logic       jr;
        logic [1:0] extr_word;
        logic [1:0] lh_to_reg;
    } exmem_ctrl_t;

    localparam exmem_ctrl_t CTRL_NOP = '0;

    function automatic logic is_jump(input exmem_ctrl_t c);
        return c.jmp | c.jal | c.jr;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// ----------------------------------------------------------------------------
// perf_counter
// Free-running event counter that wraps modulo 2^WIDTH.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low clear
//   en     count this edge
//   count  current value
// ----------------------------------------------------------------------------
module perf_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
// EX/MEM pipeline register. Captures EX results and the control bundle on a
// load cycle, inserts bubbles on flush or an invalid incoming slot, and holds
// when en is low. Also owns the architectural HI/LO pair, the syscall
// exit/print handling and three performance counters.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   flush, en, valid_in           bubble / load enable / incoming slot is real
//   PC_in .. LHToReg              EX-stage results and control bits
//   v0, a0                        syscall service number and argument
//   *_out, valid_out              registered copies for the MEM stage
//   hi_out, lo_out                architectural HI/LO
//   halt                          sticky halt after an exit syscall
//   disp_data, disp_strobe        print-syscall value and one-cycle strobe
//   cnt_cycles/jumps/branches     performance counters
// ----------------------------------------------------------------------------
module ex_mem_stage
    import cpu_pkg::*;
#(
    parameter int PC_BITS   = 32,
    parameter int IR_BITS   = 32,
    parameter int DATA_BITS = 32,
    parameter int CNT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 en,
    input  logic                 valid_in,
    input  logic [PC_BITS-1:0]   PC_in,
    input  logic [IR_BITS-1:0]   IR_in,
    input  logic [DATA_BITS-1:0] alu_result,
    input  logic [DATA_BITS-1:0] alu_result_hi,
    input  logic [DATA_BITS-1:0] store_data,
    input  logic [REGNUM_W-1:0]  write,
    input  logic                 RegWrite,
    input  logic                 MemWrite,
    input  logic                 MemToReg,
    input  logic                 ToLH,
    input  logic                 Syscall,
    input  logic                 Sh,
    input  logic                 Sb,
    input  logic                 ExtrSigned,
    input  logic                 Jmp,
    input  logic                 Jal,
    input  logic                 Jr,
    input  logic                 branch_taken,
    input  logic [1:0]           ExtrWord,
    input  logic [1:0]           LHToReg,
    input  logic [DATA_BITS-1:0] v0,
    input  logic [DATA_BITS-1:0] a0,
    output logic [PC_BITS-1:0]   PC_out,
    output logic [IR_BITS-1:0]   IR_out,
    output logic [DATA_BITS-1:0] alu_result_out,
    output logic [DATA_BITS-1:0] store_data_out,
    output logic [REGNUM_W-1:0]  write_out,
    output logic                 RegWrite_out,
    output logic                 MemWrite_out,
    output logic                 MemToReg_out,
    output logic                 ToLH_out,
    output logic                 Syscall_out,
    output logic                 Sh_out,
    output logic                 Sb_out,
    output logic                 ExtrSigned_out,
    output logic                 Jmp_out,
    output logic                 Jal_out,
    output logic                 Jr_out,
    output logic [1:0]           ExtrWord_out,
    output logic [1:0]           LHToReg_out,
    output logic                 valid_out,
    output logic [DATA_BITS-1:0] hi_out,
    output logic [DATA_BITS-1:0] lo_out,
    output logic                 halt,
    output logic [DATA_BITS-1:0] disp_data,
    output logic                 disp_strobe,
    output logic [CNT_BITS-1:0]  cnt_cycles,
    output logic [CNT_BITS-1:0]  cnt_jumps,
    output logic [CNT_BITS-1:0]  cnt_branches
);

    exmem_ctrl_t ctrl_in;
    exmem_ctrl_t ctrl_q;
    logic        accept;
    logic        bubble;
    logic        sys_exit;
    logic        sys_print;

    always_comb begin
        ctrl_in             = CTRL_NOP;
        ctrl_in.reg_write   = RegWrite;
        ctrl_in.mem_write   = MemWrite;
        ctrl_in.mem_to_reg  = MemToReg;
        ctrl_in.to_lh       = ToLH;
        ctrl_in.syscall     = Syscall;
        ctrl_in.sh          = Sh;
        ctrl_in.sb          = Sb;
        ctrl_in.extr_signed = ExtrSigned;
        ctrl_in.jmp         = Jmp;
        ctrl_in.jal         = Jal;
        ctrl_in.jr          = Jr;
        ctrl_in.extr_word   = ExtrWord;
        ctrl_in.lh_to_reg   = LHToReg;
    end

    // Priority: halt freezes, then flush, then the load-enable decision.
    assign accept    = !halt && !flush && en && valid_in;
    assign bubble    = !halt && (flush || (en && !valid_in));
    assign sys_exit  = accept && Syscall && (v0 == DATA_BITS'(SYSCALL_EXIT));
    assign sys_print = accept && Syscall && (v0 == DATA_BITS'(SYSCALL_PRINT));

    // ---- EX -> MEM register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC_out         <= '0;
            IR_out         <= '0;
            alu_result_out <= '0;
            store_data_out <= '0;
            write_out      <= '0;
            ctrl_q         <= CTRL_NOP;
            valid_out      <= 1'b0;
        end else if (bubble) begin
            PC_out         <= '0;
            IR_out         <= '0;
            alu_result_out <= '0;
            store_data_out <= '0;
            write_out      <= '0;
            ctrl_q         <= CTRL_NOP;
            valid_out      <= 1'b0;
        end else if (accept) begin
            PC_out         <= PC_in;
            IR_out         <= IR_in;
            alu_result_out <= alu_result;
            store_data_out <= store_data;
            write_out      <= write;
            ctrl_q         <= ctrl_in;
            valid_out      <= 1'b1;
        end
    end

    // Architectural state: HI/LO survive bubbles; halt is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_out      <= '0;
            lo_out      <= '0;
            halt        <= 1'b0;
            disp_data   <= '0;
            disp_strobe <= 1'b0;
        end else begin
            disp_strobe <= sys_print;
            if (accept && ToLH) begin
                hi_out <= alu_result_hi;
                lo_out <= alu_result;
            end
            if (sys_exit) begin
                halt <= 1'b1;
            end
            if (sys_print) begin
                disp_data <= a0;
            end
        end
    end

    assign RegWrite_out   = ctrl_q.reg_write;
    assign MemWrite_out   = ctrl_q.mem_write;
    assign MemToReg_out   = ctrl_q.mem_to_reg;
    assign ToLH_out       = ctrl_q.to_lh;
    assign Syscall_out    = ctrl_q.syscall;
    assign Sh_out         = ctrl_q.sh;
    assign Sb_out         = ctrl_q.sb;
    assign ExtrSigned_out = ctrl_q.extr_signed;
    assign Jmp_out        = ctrl_q.jmp;
    assign Jal_out        = ctrl_q.jal;
    assign Jr_out         = ctrl_q.jr;
    assign ExtrWord_out   = ctrl_q.extr_word;
    assign LHToReg_out    = ctrl_q.lh_to_reg;

    perf_counter #(.WIDTH(CNT_BITS)) u_cnt_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (!halt),
        .count (cnt_cycles)
    );

    perf_counter #(.WIDTH(CNT_BITS)) u_cnt_jumps (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept && is_jump(ctrl_in)),
        .count (cnt_jumps)
    );

    // A taken branch that is also flagged as a jump is counted only as a jump.
    perf_counter #(.WIDTH(CNT_BITS)) u_cnt_branches (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept && branch_taken && !is_jump(ctrl_in)),
        .count (cnt_branches)
    );

endmodule
